// File: rtl/ik_swift_iter_ctrl_pkg.sv
// ik_swift_ctrl_pkg: shared types and helpers for the ik_swift iteration
// sequencer. It holds the sequencer state enum, the default joint count and
// word width, and the saturating magnitude used by the convergence scan.
package ik_swift_ctrl_pkg;

  localparam int N_JOINT_DEF = 6;
  localparam int W_DEF       = 36;
  localparam int IDX_W       = 3;   // joint index width (worst_joint port width)

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    SCAN  = 3'd3,
    LOAD  = 3'd4,
    DONE  = 3'd5
  } state_t;

  // |v| for a signed Q19.16 word. The most negative code has no positive
  // counterpart, so it clamps to the largest positive code.
  function automatic logic [W_DEF-1:0] abs_sat(input logic signed [W_DEF-1:0] v);
    logic [W_DEF-1:0] r;
    if (!v[W_DEF-1])
      r = v;
    else if (v == {1'b1, {(W_DEF-1){1'b0}}})
      r = {1'b0, {(W_DEF-1){1'b1}}};
    else
      r = -v;
    return r;
  endfunction

endpackage

// File: rtl/ik_swift_iter_ctrl_if.sv
// ik_swift_iter_ctrl_if: the register-side and core-side signals of the
// iteration sequencer.
//   master : software/core side (drives go, abort, limits, core_done, deltas)
//   slave  : the sequencer (drives core controls and status)
interface ik_swift_iter_ctrl_if #(
  parameter int N_JOINT = 6,
  parameter int W       = 36,
  parameter int ITER_W  = 16
);
  logic                 go;
  logic                 abort;
  logic [ITER_W-1:0]    max_iter;
  logic [W-1:0]         tol;
  logic [N_JOINT-1:0]   joint_mask;
  logic                 core_done;
  logic [N_JOINT*W-1:0] core_delta;
  logic                 core_en;
  logic                 core_clr;
  logic                 param_load;
  logic                 busy;
  logic                 done;
  logic                 converged;
  logic                 iter_limit;
  logic                 timeout;
  logic [ITER_W-1:0]    iter_count;
  logic [2:0]           worst_joint;

  modport master (
    output go, abort, max_iter, tol, joint_mask, core_done, core_delta,
    input  core_en, core_clr, param_load, busy, done, converged, iter_limit,
           timeout, iter_count, worst_joint
  );

  modport slave (
    input  go, abort, max_iter, tol, joint_mask, core_done, core_delta,
    output core_en, core_clr, param_load, busy, done, converged, iter_limit,
           timeout, iter_count, worst_joint
  );
endinterface

// File: rtl/ik_swift_iter_ctrl_delta_scan.sv
// ik_delta_scan: latches the per-joint deltas when the core reports done and
// walks them one joint per cycle against the tolerance.
//   clk, reset     : clock, synchronous active-high reset
//   i_start        : latch i_delta and begin a scan at joint 0
//   i_clr          : abandon any scan and clear worst_joint (abort / new job)
//   i_delta        : flat per-joint deltas, joint i at [i*W +: W]
//   i_mask, i_tol  : participation mask and unsigned tolerance (live)
//   o_finish       : high on the cycle the last joint is examined
//   o_exceed       : any unmasked joint so far, including this cycle, > tol
//   o_worst_joint  : last joint index found exceeding tol
module ik_delta_scan
  import ik_swift_ctrl_pkg::*;
#(
  parameter int N_JOINT = N_JOINT_DEF,
  parameter int W       = W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic                 i_clr,
  input  logic [N_JOINT*W-1:0] i_delta,
  input  logic [N_JOINT-1:0]   i_mask,
  input  logic [W-1:0]         i_tol,
  output logic                 o_finish,
  output logic                 o_exceed,
  output logic [IDX_W-1:0]     o_worst_joint
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_JOINT - 1);

  logic [N_JOINT-1:0][W-1:0] r_delta;
  logic [IDX_W-1:0]          r_idx;
  logic                      r_active;
  logic                      r_exceed;
  logic [IDX_W-1:0]          r_worst;

  logic [W-1:0] w_cur;
  logic         w_msk;
  logic         w_hit;

  // Explicit select loop keeps the index in range for any N_JOINT.
  always_comb begin
    w_cur = '0;
    w_msk = 1'b0;
    for (int i = 0; i < N_JOINT; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_cur = r_delta[i];
        w_msk = i_mask[i];
      end
    end
  end

  assign w_hit         = r_active && w_msk && (abs_sat(w_cur) > i_tol);
  assign o_finish      = r_active && (r_idx == LAST_IDX);
  assign o_exceed      = r_exceed | w_hit;
  assign o_worst_joint = r_worst;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_delta  <= '0;
      r_idx    <= '0;
      r_active <= 1'b0;
      r_exceed <= 1'b0;
      r_worst  <= '0;
    end else if (i_clr) begin
      r_idx    <= '0;
      r_active <= 1'b0;
      r_exceed <= 1'b0;
      r_worst  <= '0;
    end else if (i_start) begin
      r_delta  <= i_delta;
      r_idx    <= '0;
      r_active <= 1'b1;
      r_exceed <= 1'b0;
    end else if (r_active) begin
      if (w_hit) begin
        r_exceed <= 1'b1;
        r_worst  <= r_idx;
      end
      if (o_finish) r_active <= 1'b0;
      else          r_idx    <= r_idx + 1'b1;
    end
  end

endmodule

// File: rtl/ik_swift_iter_ctrl.sv
// ik_swift_iter_ctrl: iteration sequencer for the ik_swift core. Clears and
// runs the core, scans the returned joint deltas against tol, and either
// finishes (converged / iter_limit / timeout) or loads the updated DH
// parameters and iterates again.
//   clk, reset : clock, synchronous active-high reset
//   io_bus     : slave side of ik_swift_iter_ctrl_if (go/abort/max_iter/tol/
//                joint_mask/core_done/core_delta in; core_en/core_clr/
//                param_load and status out)
module ik_swift_iter_ctrl
  import ik_swift_ctrl_pkg::*;
#(
  parameter int                N_JOINT    = N_JOINT_DEF,
  parameter int                W          = W_DEF,
  parameter int                ITER_W     = 16,
  parameter int                WDOG_W     = 20,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT = 20'hFFFFF
) (
  input  logic          clk,
  input  logic          reset,
  ik_swift_iter_ctrl_if.slave io_bus
);

  state_t              r_state, w_state_nxt;
  logic [WDOG_W-1:0]   r_wdog;
  logic [ITER_W-1:0]   r_iter;
  logic                r_conv, r_lim, r_to;

  logic [WDOG_W-1:0]   w_wdog_inc;
  logic [ITER_W:0]     w_iter_p1, w_max_eff;
  logic                w_lim_hit;
  logic                w_job_go;
  logic                w_scan_start, w_scan_clr, w_scan_fin, w_exceed;
  logic                w_set_conv, w_set_lim, w_set_to, w_iter_inc;
  logic [IDX_W-1:0]    w_worst;

  assign w_wdog_inc = r_wdog + 1'b1;
  // Compare one bit wider so iter_count+1 cannot wrap; max_iter 0 acts as 1.
  assign w_iter_p1  = {1'b0, r_iter} + {{ITER_W{1'b0}}, 1'b1};
  assign w_max_eff  = (io_bus.max_iter == '0) ? {{ITER_W{1'b0}}, 1'b1}
                                              : {1'b0, io_bus.max_iter};
  assign w_lim_hit  = (w_iter_p1 >= w_max_eff);

  assign w_job_go   = ((r_state == IDLE) || (r_state == DONE)) &&
                      io_bus.go && !io_bus.abort;
  assign w_scan_clr = io_bus.abort | w_job_go;

  ik_delta_scan #(.N_JOINT(N_JOINT), .W(W)) u_scan (
    .clk           (clk),
    .reset         (reset),
    .i_start       (w_scan_start),
    .i_clr         (w_scan_clr),
    .i_delta       (io_bus.core_delta),
    .i_mask        (io_bus.joint_mask),
    .i_tol         (io_bus.tol),
    .o_finish      (w_scan_fin),
    .o_exceed      (w_exceed),
    .o_worst_joint (w_worst)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_scan_start = 1'b0;
    w_set_conv   = 1'b0;
    w_set_lim    = 1'b0;
    w_set_to     = 1'b0;
    w_iter_inc   = 1'b0;
    case (r_state)
      IDLE, DONE: if (io_bus.go) w_state_nxt = CLEAR;
      CLEAR:      w_state_nxt = RUN;
      RUN: begin
        // core_done takes precedence over a watchdog expiry in the same cycle
        if (io_bus.core_done) begin
          w_scan_start = 1'b1;
          w_state_nxt  = SCAN;
        end else if (w_wdog_inc == WDOG_LIMIT) begin
          w_set_to    = 1'b1;
          w_state_nxt = DONE;
        end
      end
      SCAN: begin
        if (w_scan_fin) begin
          w_iter_inc = 1'b1;
          if (!w_exceed) begin
            w_set_conv  = 1'b1;
            w_state_nxt = DONE;
          end else if (w_lim_hit) begin
            w_set_lim   = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = LOAD;
          end
        end
      end
      LOAD:    w_state_nxt = CLEAR;
      default: w_state_nxt = IDLE;
    endcase
    if (io_bus.abort) begin
      w_state_nxt  = IDLE;
      w_scan_start = 1'b0;
      w_set_conv   = 1'b0;
      w_set_lim    = 1'b0;
      w_set_to     = 1'b0;
      w_iter_inc   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_wdog  <= '0;
      r_iter  <= '0;
      r_conv  <= 1'b0;
      r_lim   <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == CLEAR)    r_wdog <= '0;
      else if (r_state == RUN) r_wdog <= w_wdog_inc;
      if (io_bus.abort || w_job_go) begin
        r_iter <= '0;
        r_conv <= 1'b0;
        r_lim  <= 1'b0;
        r_to   <= 1'b0;
      end else begin
        if (w_iter_inc && (r_iter != '1)) r_iter <= r_iter + 1'b1;
        if (w_set_conv) r_conv <= 1'b1;
        if (w_set_lim)  r_lim  <= 1'b1;
        if (w_set_to)   r_to   <= 1'b1;
      end
    end
  end

  assign io_bus.core_en     = (r_state == RUN);
  assign io_bus.core_clr    = (r_state == CLEAR);
  assign io_bus.param_load  = (r_state == LOAD);
  assign io_bus.busy        = (r_state != IDLE) && (r_state != DONE);
  assign io_bus.done        = (r_state == DONE);
  assign io_bus.converged   = r_conv;
  assign io_bus.iter_limit  = r_lim;
  assign io_bus.timeout     = r_to;
  assign io_bus.iter_count  = r_iter;
  assign io_bus.worst_joint = w_worst;

endmodule

// File: tb/tb_ik_swift_iter_ctrl.sv
module tb_ik_swift_iter_ctrl;
  localparam int NJ = 6;
  localparam int W  = 36;
  localparam int IW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ik_swift_iter_ctrl_if #(.N_JOINT(NJ), .W(W), .ITER_W(IW)) bus ();

  ik_swift_iter_ctrl #(
    .N_JOINT(NJ), .W(W), .ITER_W(IW), .WDOG_W(20), .WDOG_LIMIT(20'd100)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  typedef struct {
    logic          conv;
    logic          lim;
    logic          to;
    logic [IW-1:0] iter;
    logic [2:0]    worst;
    bit            chk_worst;
    int            loads;
    int            runcyc;   // -1: not checked
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // per-job core model configuration
  int                  sp_j;
  int                  sw_iter;
  logic signed [W-1:0] sp_early, sp_late;
  bit                  resp_on;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {bus.core_en, bus.core_clr, bus.param_load, bus.busy, bus.done,
              bus.converged, bus.iter_limit, bus.timeout, bus.iter_count,
              bus.worst_joint}, 64'd0);
  endtask

  function automatic exp_t mk(logic c, logic l, logic t, int it, int wj, bit cw,
                              int ld, int rc);
    exp_t e;
    e.conv = c; e.lim = l; e.to = t; e.iter = IW'(it); e.worst = 3'(wj);
    e.chk_worst = cw; e.loads = ld; e.runcyc = rc;
    return e;
  endfunction

  // Background deltas alternate +/-0x80; joint sp_j gets sp_early on
  // iterations below sw_iter and sp_late afterwards.
  task automatic drive_delta(input int it);
    logic signed [W-1:0] v;
    for (int j = 0; j < NJ; j++) begin
      v = (j % 2 == 1) ? -36'sh80 : 36'sh80;
      if (j == sp_j) v = (it < sw_iter) ? sp_early : sp_late;
      bus.core_delta[j*W +: W] = v;
    end
  endtask

  // mode 0: normal job, 1: abort+go at scan idx 3, 2: reset during RUN
  task automatic run_job(input exp_t e, input int mode);
    int   run_cnt, run_tot, loads, it, scan_neg;
    bit   prev_load, fin;
    exp_t g;
    run_cnt = 0; run_tot = 0; loads = 0; it = 0; scan_neg = -1;
    prev_load = 0; fin = 0;
    if (mode == 0) sb.push_back(e);
    @(negedge clk);
    bus.go = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      bus.go        = 1'b0;
      bus.core_done = 1'b0;
      if (scan_neg >= 0) scan_neg++;
      if (prev_load) chk("clr_after_load", bus.core_clr, 1);
      prev_load = bus.param_load;
      if (bus.param_load) loads++;
      if (bus.core_en) begin run_cnt++; run_tot++; end
      else run_cnt = 0;
      if (mode == 2 && bus.core_en && run_cnt == 2) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_idle("reset_mid_run");
        return;
      end
      if (mode == 1 && scan_neg == 4) begin
        bus.abort = 1'b1;
        bus.go    = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.go    = 1'b0;
        chk_idle("abort_in_scan");
        return;
      end
      if (bus.core_en && resp_on && run_cnt == 5) begin
        drive_delta(it);
        bus.core_done = 1'b1;
        it++;
        scan_neg = 0;
      end
      if (bus.done) begin
        fin = 1;
        break;
      end
    end
    chk("job_reaches_done", fin, 1);
    if (mode == 0 && sb.size() > 0) begin
      g = sb.pop_front();
      if (fin) begin
        chk("converged",  bus.converged,  g.conv);
        chk("iter_limit", bus.iter_limit, g.lim);
        chk("timeout",    bus.timeout,    g.to);
        chk("iter_count", bus.iter_count, g.iter);
        chk("load_count", loads, g.loads);
        chk("core_en_in_done", bus.core_en, 0);
        chk("busy_in_done",    bus.busy,    0);
        if (g.chk_worst) chk("worst_joint", bus.worst_joint, g.worst);
        if (g.runcyc >= 0) chk("run_cycles", run_tot, g.runcyc);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.go = 0; bus.abort = 0; bus.core_done = 0; bus.core_delta = '0;
    bus.max_iter = 16'd10; bus.tol = 36'h100; bus.joint_mask = 6'h3F;
    sp_j = -1; sw_iter = 0; sp_early = '0; sp_late = '0; resp_on = 1;
    repeat (3) @(negedge clk);
    chk_idle("reset_state");
    reset = 1'b0;
    @(negedge clk);
    chk_idle("idle_after_reset");

    // 1: converge on first iteration
    run_job(mk(1, 0, 0, 1, 0, 0, 0, -1), 0);

    // 2: joint 2 large for two iterations, then small
    sp_j = 2; sw_iter = 2; sp_early = 36'sh1_0000; sp_late = 36'sh10;
    run_job(mk(1, 0, 0, 3, 0, 0, 2, -1), 0);

    // 3: joint 5 never converges, limit 4
    bus.max_iter = 16'd4;
    sp_j = 5; sw_iter = 0; sp_early = -36'sh2_0000; sp_late = -36'sh2_0000;
    run_job(mk(0, 1, 0, 4, 5, 1, 3, -1), 0);

    // 4a: most negative delta on masked-out joint 0
    bus.max_iter = 16'd10; bus.joint_mask = 6'h3E;
    sp_j = 0; sp_early = 36'sh8_0000_0000; sp_late = 36'sh8_0000_0000;
    run_job(mk(1, 0, 0, 1, 0, 0, 0, -1), 0);

    // 4b: same with joint 0 enabled; max_iter 0 behaves as 1
    bus.joint_mask = 6'h3F; bus.max_iter = 16'd0;
    run_job(mk(0, 1, 0, 1, 0, 1, 0, -1), 0);

    // tolerance boundary: |delta| == tol is within, tol+1 is not
    bus.max_iter = 16'd10;
    sp_j = 1; sp_early = -36'sh100; sp_late = -36'sh100;
    run_job(mk(1, 0, 0, 1, 0, 0, 0, -1), 0);
    bus.max_iter = 16'd1;
    sp_early = 36'sh101; sp_late = 36'sh101;
    run_job(mk(0, 1, 0, 1, 1, 1, 0, -1), 0);

    // 5: watchdog timeout after 100 RUN cycles
    bus.max_iter = 16'd10; sp_j = -1; resp_on = 0;
    run_job(mk(0, 0, 1, 0, 0, 0, 0, 100), 0);
    resp_on = 1;

    // 6: abort in scan, reset in run, then a clean job
    run_job(mk(0, 0, 0, 0, 0, 0, 0, -1), 1);
    run_job(mk(0, 0, 0, 0, 0, 0, 0, -1), 2);
    run_job(mk(1, 0, 0, 1, 0, 0, 0, -1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
